// File: rtl/hamming_pkg.sv
// hamming_pkg: shared SECDED Hamming helpers for the decoder and its future encoder.
//   par_w(data_w)           smallest P with 2^P >= data_w+P+1
//   is_pow2(pos)            true for parity positions 1,2,4,...
//   extract_data(code, cw)  gathers the non-power-of-two positions 3.. into data bits 0..
package hamming_pkg;
  localparam int MAX_W = 256;
  typedef logic [MAX_W-1:0] wide_t;
  function automatic int par_w(input int data_w);
    int r = 0;
    for (int p = 16; p >= 1; p--) if ((1 << p) >= data_w + p + 1) r = p;
    return r;
  endfunction
  function automatic logic is_pow2(input int pos);
    return pos > 0 && (pos & (pos - 1)) == 0;
  endfunction
  // Works on a fixed wide vector so one function serves every DATA_W; callers cast in and out.
  function automatic wide_t extract_data(input wide_t code, input int code_w);
    wide_t d = '0;
    int j = 0;
    for (int pos = 3; pos < MAX_W; pos++)
      if (pos < code_w && !is_pow2(pos)) begin
        d[j] = code[pos];
        j++;
      end
    return d;
  endfunction
endpackage

// File: rtl/hamming_secded_pipe_if.sv
// hamming_secded_pipe_if: code-word input stream and decoded-result output stream.
//   in_valid/in_ready/in_code                       code-word source -> decoder
//   out_valid/out_ready/out_data/out_single/
//   out_double/out_syndrome                         decoder -> consumer
//   master: testbench/system side; slave: decoder side.
interface hamming_secded_pipe_if #(parameter int DATA_W = 8);
  import hamming_pkg::*;
  localparam int PAR_W = par_w(DATA_W);
  localparam int CODE_W = DATA_W + PAR_W + 1;
  logic in_valid;
  logic in_ready;
  logic [CODE_W-1:0] in_code;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_data;
  logic out_single;
  logic out_double;
  logic [PAR_W-1:0] out_syndrome;
  modport master(output in_valid, in_code, out_ready,
                 input in_ready, out_valid, out_data, out_single, out_double, out_syndrome);
  modport slave(input in_valid, in_code, out_ready,
                output in_ready, out_valid, out_data, out_single, out_double, out_syndrome);
endinterface

// File: rtl/hamming_syndrome.sv
// hamming_syndrome: combinational Hamming syndrome and overall parity of one code word.
//   code_i  code word, bit 0 = overall parity, bits 1.. = Hamming positions
//   syn_o   XOR of the indices of all set positions
//   par_o   XOR of every bit (0 for an error-free word)
module hamming_syndrome #(
  parameter int CODE_W = 13,
  parameter int PAR_W = 4
) (
  input  logic [CODE_W-1:0] code_i,
  output logic [PAR_W-1:0]  syn_o,
  output logic              par_o
);
  always_comb begin
    syn_o = '0;
    for (int pos = 1; pos < CODE_W; pos++) if (code_i[pos]) syn_o = syn_o ^ PAR_W'(pos);
  end
  assign par_o = ^code_i;
endmodule

// File: rtl/hamming_secded_pipe.sv
// hamming_secded_pipe: two-stage pipelined SECDED decoder with valid/ready flow and error counters.
//   clk, rst     clock, synchronous active-high reset
//   bus          slave side of hamming_secded_pipe_if (input and output streams)
//   cnt_clr      synchronous clear of both counters, wins over an increment
//   corr_cnt     saturating count of delivered single-error words
//   uncorr_cnt   saturating count of delivered double-error words
module hamming_secded_pipe
  import hamming_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  hamming_secded_pipe_if.slave  bus,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      corr_cnt,
  output logic [CNT_W-1:0]      uncorr_cnt
);
  localparam int PAR_W = par_w(DATA_W);
  localparam int CODE_W = DATA_W + PAR_W + 1;
  logic              s1_valid_q, s1_par_q, out_valid_q, out_single_q, out_double_q;
  logic [PAR_W-1:0]  s1_syn_q, out_syn_q, syn;
  logic [CODE_W-1:0] s1_code_q, fix_code;
  logic [DATA_W-1:0] out_data_q, data_d;
  logic [CNT_W-1:0]  corr_q, uncorr_q, corr_d, uncorr_d;
  logic              par, s2_adv, in_fire, out_fire, in_range, single_d, double_d;
  hamming_syndrome #(.CODE_W(CODE_W), .PAR_W(PAR_W)) u_syn (
    .code_i(bus.in_code),
    .syn_o (syn),
    .par_o (par)
  );
  assign s2_adv = !out_valid_q || bus.out_ready;
  assign bus.in_ready = !rst && (!s1_valid_q || s2_adv);
  assign in_fire = bus.in_valid && bus.in_ready;
  assign out_fire = out_valid_q && bus.out_ready;
  // A syndrome beyond the last position cannot come from a single flip.
  assign in_range = s1_syn_q != '0 && 32'(s1_syn_q) < 32'(CODE_W);
  always_comb begin
    fix_code = s1_code_q ^ ((s1_par_q && in_range) ? CODE_W'(1) << s1_syn_q : '0);
    data_d = DATA_W'(extract_data(wide_t'(fix_code), CODE_W));
    single_d = s1_par_q && (s1_syn_q == '0 || in_range);
    double_d = s1_syn_q != '0 && (!s1_par_q || !in_range);
    corr_d = cnt_clr ? '0 : (out_fire && out_single_q && corr_q != '1) ? corr_q + 1'b1 : corr_q;
    uncorr_d = cnt_clr ? '0 : (out_fire && out_double_q && uncorr_q != '1) ? uncorr_q + 1'b1 : uncorr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_par_q <= 1'b0;
      s1_syn_q <= '0;
      s1_code_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_single_q <= 1'b0;
      out_double_q <= 1'b0;
      out_syn_q <= '0;
      corr_q <= '0;
      uncorr_q <= '0;
    end else begin
      if (in_fire) begin
        s1_syn_q <= syn;
        s1_par_q <= par;
        s1_code_q <= bus.in_code;
      end
      s1_valid_q <= in_fire || (s1_valid_q && !s2_adv);
      if (s2_adv) out_valid_q <= s1_valid_q;
      if (s2_adv && s1_valid_q) begin
        out_data_q <= data_d;
        out_single_q <= single_d;
        out_double_q <= double_d;
        out_syn_q <= s1_syn_q;
      end
      corr_q <= corr_d;
      uncorr_q <= uncorr_d;
    end
  end
  assign bus.out_valid = out_valid_q;
  assign bus.out_data = out_data_q;
  assign bus.out_single = out_single_q;
  assign bus.out_double = out_double_q;
  assign bus.out_syndrome = out_syn_q;
  assign corr_cnt = corr_q;
  assign uncorr_cnt = uncorr_q;
endmodule

// File: tb/tb_hamming_secded_pipe.sv
// tb_hamming_secded_pipe: directed bench for hamming_secded_pipe (DATA_W=8, CNT_W=2).
module tb_hamming_secded_pipe;
  logic clk, rst, cnt_clr;
  logic [1:0] corr_cnt, uncorr_cnt;
  int n_cmp = 0, n_err = 0;
  hamming_secded_pipe_if #(.DATA_W(8)) bus ();
  hamming_secded_pipe #(.DATA_W(8), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .cnt_clr(cnt_clr),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic xfer(input logic [12:0] code, output logic [7:0] d, output logic sg, output logic db,
                      output logic [3:0] sy, output int lat);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_code = code;
    #1;
    while (!bus.in_ready && n < 20) begin
      step;
      n++;
    end
    step;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      step;
      lat++;
    end
    d = bus.out_data;
    sg = bus.out_single;
    db = bus.out_double;
    sy = bus.out_syndrome;
    step;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    step;
    step;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b exp 0", bus.in_ready); end
    n_cmp++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data got %h exp 00", bus.out_data); end
    n_cmp++; if (corr_cnt !== 2'd0 || uncorr_cnt !== 2'd0) begin n_err++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", corr_cnt, uncorr_cnt); end
    rst = 1'b0;
    step;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got %b exp 1", bus.in_ready); end
  endtask
  task automatic test_clean;
    logic [7:0] d; logic sg, db; logic [3:0] sy; int lat;
    xfer(13'h144E, d, sg, db, sy, lat);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL clean_latency got %0d exp 2", lat); end
    n_cmp++; if ({d, sg, db, sy} !== {8'hA5, 1'b0, 1'b0, 4'd0}) begin n_err++; $display("FAIL clean_a5 got d=%h s=%b d2=%b syn=%0d exp d=a5 s=0 d2=0 syn=0", d, sg, db, sy); end
    xfer(13'h0000, d, sg, db, sy, lat);
    n_cmp++; if ({d, sg, db, sy} !== {8'h00, 1'b0, 1'b0, 4'd0}) begin n_err++; $display("FAIL clean_zero got d=%h s=%b d2=%b syn=%0d exp d=00 s=0 d2=0 syn=0", d, sg, db, sy); end
    n_cmp++; if (corr_cnt !== 2'd0 || uncorr_cnt !== 2'd0) begin n_err++; $display("FAIL clean_cnt got %0d/%0d exp 0/0", corr_cnt, uncorr_cnt); end
  endtask
  task automatic test_single;
    logic [7:0] d; logic sg, db; logic [3:0] sy; int lat;
    xfer(13'h140E, d, sg, db, sy, lat);
    n_cmp++; if ({d, sg, db, sy} !== {8'hA5, 1'b1, 1'b0, 4'd6}) begin n_err++; $display("FAIL single_pos6 got d=%h s=%b d2=%b syn=%0d exp d=a5 s=1 d2=0 syn=6", d, sg, db, sy); end
    n_cmp++; if (corr_cnt !== 2'd1) begin n_err++; $display("FAIL single_corr_cnt got %0d exp 1", corr_cnt); end
    xfer(13'h144F, d, sg, db, sy, lat);
    n_cmp++; if ({d, sg, db, sy} !== {8'hA5, 1'b1, 1'b0, 4'd0}) begin n_err++; $display("FAIL single_overall got d=%h s=%b d2=%b syn=%0d exp d=a5 s=1 d2=0 syn=0", d, sg, db, sy); end
    xfer(13'h044E, d, sg, db, sy, lat);
    n_cmp++; if ({d, sg, db, sy} !== {8'hA5, 1'b1, 1'b0, 4'd12}) begin n_err++; $display("FAIL single_pos12 got d=%h s=%b d2=%b syn=%0d exp d=a5 s=1 d2=0 syn=12", d, sg, db, sy); end
    n_cmp++; if (corr_cnt !== 2'd3) begin n_err++; $display("FAIL single_corr_cnt3 got %0d exp 3", corr_cnt); end
  endtask
  task automatic test_double;
    logic [7:0] d; logic sg, db; logic [3:0] sy; int lat;
    xfer(13'h1406, d, sg, db, sy, lat);
    n_cmp++; if ({d, sg, db, sy} !== {8'hA0, 1'b0, 1'b1, 4'd5}) begin n_err++; $display("FAIL double_3_6 got d=%h s=%b d2=%b syn=%0d exp d=a0 s=0 d2=1 syn=5", d, sg, db, sy); end
    n_cmp++; if (uncorr_cnt !== 2'd1) begin n_err++; $display("FAIL double_uncorr_cnt got %0d exp 1", uncorr_cnt); end
    xfer(13'h0117, d, sg, db, sy, lat);
    n_cmp++; if ({d, sg, db, sy} !== {8'h00, 1'b0, 1'b1, 4'd15}) begin n_err++; $display("FAIL double_syn_range got d=%h s=%b d2=%b syn=%0d exp d=00 s=0 d2=1 syn=15", d, sg, db, sy); end
    n_cmp++; if (uncorr_cnt !== 2'd2) begin n_err++; $display("FAIL double_uncorr_cnt2 got %0d exp 2", uncorr_cnt); end
  endtask
  task automatic test_back_to_back;
    logic [12:0] codes [4] = '{13'h144E, 13'h0000, 13'h140E, 13'h1406};
    logic [7:0] ed [4] = '{8'hA5, 8'h00, 8'hA5, 8'hA0};
    logic es [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic edb [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] esy [4] = '{4'd0, 4'd0, 4'd6, 4'd5};
    int sent = 0, got = 0;
    logic fell = 1'b0, pv = 1'b0, ps = 1'b0, pdb = 1'b0;
    logic [7:0] pd = '0;
    logic [3:0] psy = '0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      bus.out_ready = !(c >= 1 && c <= 3);
      bus.in_valid = sent < 4;
      if (sent < 4) bus.in_code = codes[sent];
      #1;
      if (sent < 4 && !bus.in_ready) fell = 1'b1;
      if (pv) begin
        n_cmp++;
        if ({bus.out_valid, bus.out_data, bus.out_single, bus.out_double, bus.out_syndrome} !== {1'b1, pd, ps, pdb, psy}) begin
          n_err++;
          $display("FAIL bp_hold got v=%b d=%h s=%b d2=%b syn=%0d exp v=1 d=%h s=%b d2=%b syn=%0d",
                   bus.out_valid, bus.out_data, bus.out_single, bus.out_double, bus.out_syndrome, pd, ps, pdb, psy);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if ({bus.out_data, bus.out_single, bus.out_double, bus.out_syndrome} !== {ed[got], es[got], edb[got], esy[got]}) begin
          n_err++;
          $display("FAIL bp_word%0d got d=%h s=%b d2=%b syn=%0d exp d=%h s=%b d2=%b syn=%0d", got,
                   bus.out_data, bus.out_single, bus.out_double, bus.out_syndrome, ed[got], es[got], edb[got], esy[got]);
        end
        got++;
      end
      pv = bus.out_valid && !bus.out_ready;
      pd = bus.out_data;
      ps = bus.out_single;
      pdb = bus.out_double;
      psy = bus.out_syndrome;
      if (bus.in_valid && bus.in_ready) sent++;
      step;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    n_cmp++; if (got !== 4) begin n_err++; $display("FAIL bp_count got %0d exp 4", got); end
    n_cmp++; if (fell !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_fall got %b exp 1", fell); end
    step;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_dup got %b exp 0", bus.out_valid); end
  endtask
  task automatic test_counters;
    logic [7:0] d; logic sg, db; logic [3:0] sy; int lat;
    cnt_clr = 1'b1;
    step;
    cnt_clr = 1'b0;
    n_cmp++; if (corr_cnt !== 2'd0 || uncorr_cnt !== 2'd0) begin n_err++; $display("FAIL cnt_clr got %0d/%0d exp 0/0", corr_cnt, uncorr_cnt); end
    for (int i = 0; i < 5; i++) xfer(13'h140E, d, sg, db, sy, lat);
    n_cmp++; if (corr_cnt !== 2'd3) begin n_err++; $display("FAIL cnt_saturate got %0d exp 3", corr_cnt); end
    bus.in_valid = 1'b1;
    bus.in_code = 13'h140E;
    step;
    bus.in_valid = 1'b0;
    step;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL cnt_clr_word_valid got %b exp 1", bus.out_valid); end
    cnt_clr = 1'b1;
    step;
    cnt_clr = 1'b0;
    n_cmp++; if (corr_cnt !== 2'd0) begin n_err++; $display("FAIL cnt_clr_wins got %0d exp 0", corr_cnt); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL cnt_clr_consumed got %b exp 0", bus.out_valid); end
  endtask
  task automatic test_reset_mid;
    logic [7:0] d; logic sg, db; logic [3:0] sy; int lat;
    xfer(13'h1406, d, sg, db, sy, lat);
    xfer(13'h140E, d, sg, db, sy, lat);
    n_cmp++; if (corr_cnt !== 2'd1 || uncorr_cnt !== 2'd1) begin n_err++; $display("FAIL mid_pre_cnt got %0d/%0d exp 1/1", corr_cnt, uncorr_cnt); end
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_code = 13'h144E;
    step;
    step;
    step;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin n_err++; $display("FAIL mid_full got v=%b d=%h exp v=1 d=a5", bus.out_valid, bus.out_data); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_in_ready got %b exp 0", bus.in_ready); end
    step;
    n_cmp++; if ({bus.out_valid, bus.out_data, bus.out_single, bus.out_double, bus.out_syndrome} !== 15'd0) begin
      n_err++;
      $display("FAIL mid_rst_outputs got v=%b d=%h s=%b d2=%b syn=%0d exp all 0", bus.out_valid, bus.out_data, bus.out_single, bus.out_double, bus.out_syndrome);
    end
    n_cmp++; if (corr_cnt !== 2'd0 || uncorr_cnt !== 2'd0) begin n_err++; $display("FAIL mid_rst_cnt got %0d/%0d exp 0/0", corr_cnt, uncorr_cnt); end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step;
    step;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_discard got %b exp 0", bus.out_valid); end
  endtask
  initial begin
    rst = 1'b1;
    cnt_clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_code = '0;
    bus.out_ready = 1'b1;
    test_reset;
    test_clean;
    test_single;
    test_double;
    test_back_to_back;
    test_counters;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hamming_secded_pipe.md
Name: hamming_secded_pipe

Overview:
Parametrised, pipelined SECDED (single-error-correct, double-error-detect) Hamming decoder. It is the next generation of the team's fixed 8-bit Hamming codec. It adds:
- a configurable data width,
- an overall-parity bit for double-error detection,
- a valid/ready streaming interface with backpressure,
- saturating error-statistics counters.

It sits at the receive side of any protected storage or link path, between the code-word source and the data consumer.

Parameters:
DATA_W, 8, number of payload bits (≥4).
PAR_W, derived localparam, smallest P with 2^P ≥ DATA_W+P+1 (4 for DATA_W=8); not overridable.
CODE_W, derived localparam, DATA_W+PAR_W+1 (13 for DATA_W=8).
CNT_W, 16, width of each error counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; synchronous, active-high
in_valid  input  1  code word present on in_code
in_ready  output  1  block accepts in_code this cycle
in_code  input  CODE_W  received code word; bit 0 = overall parity, bits 1..CODE_W-1 = Hamming positions 1..N
out_valid  output  1  decoded result present
out_ready  input  1  consumer accepts result
out_data  output  DATA_W  corrected payload (raw payload on double error)
out_single  output  1  single error detected and corrected
out_double  output  1  uncorrectable error
out_syndrome  output  PAR_W  Hamming syndrome of the word
cnt_clr  input  1  synchronous clear of both counters
corr_cnt  output  CNT_W  count of delivered words with out_single=1
uncorr_cnt  output  CNT_W  count of delivered words with out_double=1

Behaviour:
- Code layout
  - Parity bits sit at power-of-two positions 1,2,4,...
  - Data bits fill the remaining positions in ascending order, with data[0] at position 3.
  - Bit 0 makes even parity over all CODE_W bits.
- Stage 1 (syndrome)
  - Register the syndrome s: bit k = XOR of positions with bit k set.
  - Register the overall parity p = XOR of all CODE_W bits.
  - Register the raw word.
- Stage 2 (correct/classify), registered into the outputs:
  - s=0, p=0: clean; single=0, double=0.
  - p=1, s=0: overall-parity bit in error; data unchanged; single=1.
  - p=1, 1≤s≤N: flip position s, then extract data; single=1.
  - p=1, s>N: double=1; data raw.
  - s≠0, p=0: double=1; data extracted uncorrected.
  - single and double are never both 1.
- Latency
  - 2 cycles from in_valid&&in_ready to out_valid, when out_ready stays high.
  - Full throughput: 1 word/cycle.
- Handshake
  - Each stage has a valid bit.
  - A stage loads when it is empty or when its downstream stage advances in the same cycle.
  - in_ready = !s1_valid || s2_advance, where s2_advance = !out_valid || out_ready.
  - While out_valid=1 and out_ready=0, all of out_data, out_single, out_double, out_syndrome hold stable.
  - No word is dropped or duplicated under any backpressure pattern.
- Counters
  - Increment only on the output handshake (out_valid&&out_ready).
  - Saturate at 2^CNT_W−1; no wrap.
  - If cnt_clr coincides with an increment, cnt_clr wins: the counter becomes 0.
- Reset
  - rst clears both stage valids, out_valid, out_data, out_single, out_double, out_syndrome and both counters to 0.
  - Any in-flight words are discarded.
  - While rst=1, in_ready=0.

Decomposition:
- Package hamming_pkg holds:
  - function par_w(data_w), returning the smallest P satisfying the rule above;
  - function is_pow2(pos);
  - function extract_data(code), which maps positions to data bits.
- These functions are reused by the matching future encoder.
- One sub-module, hamming_syndrome: purely combinational; computes s and p from a CODE_W word. Used by stage 1.

Test Plan (DATA_W=8, CODE_W=13):
- Clean word: in_code=0x144E (data 0xA5) → after 2 cycles out_data=0xA5, single=0, double=0, syndrome=0.
- Single error: in_code=0x140E (position 6 flipped) → out_data=0xA5, single=1, syndrome=6, corr_cnt=1.
- Overall-parity error: in_code=0x144F → out_data=0xA5, single=1, syndrome=0.
- Double error: in_code=0x1406 (positions 3 and 6 flipped) → double=1, single=0, syndrome=5, out_data=0xA0, uncorr_cnt=1.
- Backpressure: stream 4 words with out_ready low for 3 cycles mid-stream → in_ready falls once both stages are full; outputs hold; all 4 results arrive in order with no loss.
- Counters (CNT_W=2): 5 single-error words → corr_cnt saturates at 3. Then cnt_clr in the same cycle as a 6th single-error handshake → corr_cnt=0. Finally assert rst mid-stream → out_valid=0 the next cycle and both counters are 0.
